game_countdown_timer: RTL and testbench

//  Game countdown clock for the HUD. Keeps MM:SS in four BCD digits and counts down once per second while running.

---
 rtl/game_countdown_timer.sv | 215 +++++++++++++++++++++
 tb/tb_game_countdown_timer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_countdown_timer.sv
// HUD game countdown clock: MM:SS kept as four BCD digits with pause, reload, bonus and expiry,
// plus the zero-latency slicer that maps the timer rectangle onto four digit cells for the bitmap stage.
module game_countdown_timer #(
  parameter int CLKS_PER_SEC = 31_500_000,
  parameter int START_MIN    = 2,
  parameter int START_SEC    = 0,
  parameter int BONUS_SEC    = 10,
  parameter int LOW_SEC      = 10,
  parameter int DIGIT_W      = 16,
  parameter int DIGIT_H      = 32
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        load,
  input  logic        run,
  input  logic        addBonus,
  input  logic [10:0] offsetX,
  input  logic [10:0] offsetY,
  input  logic        InsideRectangle,
  output logic [3:0]  digit,
  output logic [10:0] digitOffsetX,
  output logic [10:0] digitOffsetY,
  output logic        digitInside,
  output logic        timeUp,
  output logic        timeZero,
  output logic        lowTime
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_SEC - 1);

  localparam logic [3:0] START_MT = 4'(START_MIN / 10);
  localparam logic [3:0] START_MU = 4'(START_MIN % 10);
  localparam logic [3:0] START_ST = 4'(START_SEC / 10);
  localparam logic [3:0] START_SU = 4'(START_SEC % 10);
  localparam logic [3:0] BONUS_T  = 4'(BONUS_SEC / 10);
  localparam logic [3:0] BONUS_U  = 4'(BONUS_SEC % 10);

  localparam logic [10:0] DW      = 11'(DIGIT_W);
  localparam logic [10:0] DH      = 11'(DIGIT_H);
  localparam logic [10:0] CELLS_W = 11'(4 * DIGIT_W);

  logic [1:0]    state_reg, state_next;
  logic [PW-1:0] prescaler_reg, prescaler_next;
  logic [3:0]    min_t_reg, min_u_reg, sec_t_reg, sec_u_reg;
  logic [3:0]    min_t_next, min_u_next, sec_t_next, sec_u_next;
  logic          time_up_reg, time_up_next;

  logic count_en, tick, count_zero, bonus_en, expire_now;
  logic [3:0] d_mt, d_mu, d_st, d_su;
  logic [3:0] a_mt, a_mu, a_st, a_su;
  logic [3:0] r_mt, r_mu, r_st, r_su;
  logic [4:0] sum_su, sum_st, sum_mu, sum_mt;
  logic       c_su, c_st, c_mu;

  assign count_en   = (state_reg == ST_RUNNING) && run;
  assign tick       = count_en && (prescaler_reg == PRE_LAST);
  assign count_zero = (min_t_reg == 4'd0) && (min_u_reg == 4'd0) &&
                      (sec_t_reg == 4'd0) && (sec_u_reg == 4'd0);
  assign bonus_en   = addBonus && (state_reg != ST_EXPIRED);

  // One-second BCD decrement; a zero count stays at zero so a 00:00 start expires on its first tick.
  always_comb begin
    d_mt = min_t_reg;
    d_mu = min_u_reg;
    d_st = sec_t_reg;
    d_su = sec_u_reg;
    if (tick && !count_zero) begin
      if (sec_u_reg != 4'd0) begin
        d_su = sec_u_reg - 4'd1;
      end else begin
        d_su = 4'd9;
        if (sec_t_reg != 4'd0) begin
          d_st = sec_t_reg - 4'd1;
        end else begin
          d_st = 4'd5;
          if (min_u_reg != 4'd0) begin
            d_mu = min_u_reg - 4'd1;
          end else begin
            d_mu = 4'd9;
            d_mt = min_t_reg - 4'd1;
          end
        end
      end
    end
  end

  // Bonus is added on top of the decremented value, so tick+bonus nets BONUS_SEC-1.
  always_comb begin
    sum_su = {1'b0, d_su} + {1'b0, BONUS_U};
    c_su   = sum_su > 5'd9;
    a_su   = c_su ? 4'(sum_su - 5'd10) : sum_su[3:0];
    sum_st = {1'b0, d_st} + {1'b0, BONUS_T} + {4'd0, c_su};
    c_st   = sum_st > 5'd5;
    a_st   = c_st ? 4'(sum_st - 5'd6) : sum_st[3:0];
    sum_mu = {1'b0, d_mu} + {4'd0, c_st};
    c_mu   = sum_mu > 5'd9;
    a_mu   = c_mu ? 4'd0 : sum_mu[3:0];
    sum_mt = {1'b0, d_mt} + {4'd0, c_mu};
    a_mt   = sum_mt[3:0];
    if (sum_mt > 5'd9) begin
      a_mt = 4'd9;
      a_mu = 4'd9;
      a_st = 4'd5;
      a_su = 4'd9;
    end
  end

  always_comb begin
    r_mt = bonus_en ? a_mt : d_mt;
    r_mu = bonus_en ? a_mu : d_mu;
    r_st = bonus_en ? a_st : d_st;
    r_su = bonus_en ? a_su : d_su;
  end

  assign expire_now = tick && (r_mt == 4'd0) && (r_mu == 4'd0) &&
                      (r_st == 4'd0) && (r_su == 4'd0);

  always_comb begin
    state_next     = state_reg;
    prescaler_next = prescaler_reg;
    min_t_next     = min_t_reg;
    min_u_next     = min_u_reg;
    sec_t_next     = sec_t_reg;
    sec_u_next     = sec_u_reg;
    time_up_next   = 1'b0;
    if (load) begin
      state_next     = ST_IDLE;
      prescaler_next = '0;
      min_t_next     = START_MT;
      min_u_next     = START_MU;
      sec_t_next     = START_ST;
      sec_u_next     = START_SU;
    end else begin
      case (state_reg)
        ST_IDLE, ST_PAUSED: begin
          if (run) state_next = ST_RUNNING;
        end
        ST_RUNNING: begin
          if (!run) state_next = ST_PAUSED;
          else prescaler_next = tick ? '0 : prescaler_reg + PW'(1);
        end
        default: ;
      endcase
      if (state_reg != ST_EXPIRED) begin
        min_t_next = r_mt;
        min_u_next = r_mu;
        sec_t_next = r_st;
        sec_u_next = r_su;
      end
      if (expire_now) begin
        state_next   = ST_EXPIRED;
        time_up_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg     <= ST_IDLE;
      prescaler_reg <= '0;
      min_t_reg     <= START_MT;
      min_u_reg     <= START_MU;
      sec_t_reg     <= START_ST;
      sec_u_reg     <= START_SU;
      time_up_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prescaler_reg <= prescaler_next;
      min_t_reg     <= min_t_next;
      min_u_reg     <= min_u_next;
      sec_t_reg     <= sec_t_next;
      sec_u_reg     <= sec_u_next;
      time_up_reg   <= time_up_next;
    end
  end

  logic [6:0] sec_val;
  assign sec_val  = 7'({sec_t_reg, 3'b000}) + 7'({sec_t_reg, 1'b0}) + 7'(sec_u_reg);
  assign timeUp   = time_up_reg;
  assign timeZero = (state_reg == ST_EXPIRED);
  assign lowTime  = (min_t_reg == 4'd0) && (min_u_reg == 4'd0) &&
                    (sec_val < 7'(LOW_SEC)) && (state_reg != ST_EXPIRED);

  // Display slicer: purely combinational so the bitmap's own register is the only pipeline stage.
  logic [10:0] cell_idx;
  logic [3:0]  cell_digit [4];
  logic [3:0]  cell_val   [4];
  logic        in_cells;

  assign cell_idx      = offsetX / DW;
  assign cell_digit[0] = min_t_reg;
  assign cell_digit[1] = min_u_reg;
  assign cell_digit[2] = sec_t_reg;
  assign cell_digit[3] = sec_u_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cell
      assign cell_val[gi] = (cell_idx == 11'(gi)) ? cell_digit[gi] : 4'd0;
    end
  endgenerate

  assign in_cells     = InsideRectangle && (offsetX < CELLS_W) && (offsetY < DH);
  assign digitInside  = in_cells;
  assign digit        = in_cells ? (cell_val[0] | cell_val[1] | cell_val[2] | cell_val[3]) : 4'd0;
  assign digitOffsetX = offsetX % DW;
  assign digitOffsetY = offsetY;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Randomised bench for game_countdown_timer: stimulus pushes model expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_game_countdown_timer;

  localparam int CPS     = 4;
  localparam int SMIN    = 1;
  localparam int SSEC    = 0;
  localparam int BON     = 10;
  localparam int LOW     = 10;
  localparam int DW      = 16;
  localparam int DH      = 32;
  localparam int START_S = SMIN * 60 + SSEC;
  localparam int MAX_S   = 99 * 60 + 59;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP  = 3;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        load = 1'b0;
  logic        run = 1'b0;
  logic        addBonus = 1'b0;
  logic [10:0] offsetX = '0;
  logic [10:0] offsetY = '0;
  logic        InsideRectangle = 1'b0;
  logic [3:0]  digit;
  logic [10:0] digitOffsetX;
  logic [10:0] digitOffsetY;
  logic        digitInside;
  logic        timeUp;
  logic        timeZero;
  logic        lowTime;

  game_countdown_timer #(
    .CLKS_PER_SEC(CPS), .START_MIN(SMIN), .START_SEC(SSEC), .BONUS_SEC(BON),
    .LOW_SEC(LOW), .DIGIT_W(DW), .DIGIT_H(DH)
  ) dut (
    .clk(clk), .resetN(resetN), .load(load), .run(run), .addBonus(addBonus),
    .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
    .digit(digit), .digitOffsetX(digitOffsetX), .digitOffsetY(digitOffsetY),
    .digitInside(digitInside), .timeUp(timeUp), .timeZero(timeZero), .lowTime(lowTime)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  dig;
    logic [10:0] dox;
    logic [10:0] doy;
    logic        din;
    logic        tu;
    logic        tz;
    logic        low;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: whole seconds, a prescaler count and a mode.
  int m_mode;
  int m_secs;
  int m_pre;
  bit m_tu;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_secs = START_S;
    m_pre  = 0;
    m_tu   = 1'b0;
  endtask

  function automatic int add_bonus(input int s);
    return (s + BON > MAX_S) ? MAX_S : s + BON;
  endfunction

  task automatic model_step(input bit ld, input bit rn, input bit bn);
    bit tk;
    if (ld) begin
      model_reset();
      return;
    end
    m_tu = 1'b0;
    case (m_mode)
      M_IDLE, M_PAUSE: begin
        if (rn) m_mode = M_RUN;
        if (bn) m_secs = add_bonus(m_secs);
      end
      M_RUN: begin
        if (!rn) begin
          m_mode = M_PAUSE;
          if (bn) m_secs = add_bonus(m_secs);
        end else begin
          tk = (m_pre == CPS - 1);
          m_pre = tk ? 0 : m_pre + 1;
          if (tk && m_secs > 0) m_secs = m_secs - 1;
          if (bn) m_secs = add_bonus(m_secs);
          if (tk && m_secs == 0) begin
            m_mode = M_EXP;
            m_tu   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  endtask

  function automatic exp_t model_out(input int ox, input int oy, input bit ins);
    exp_t e;
    int mm, ss;
    int d[4];
    mm = m_secs / 60;
    ss = m_secs % 60;
    d = '{mm / 10, mm % 10, ss / 10, ss % 10};
    e.din = ins && (ox < 4 * DW) && (oy < DH);
    e.dig = 4'd0;
    if (e.din) e.dig = 4'(d[ox / DW]);
    e.dox = 11'(ox % DW);
    e.doy = 11'(oy);
    e.tu  = m_tu;
    e.tz  = (m_mode == M_EXP);
    e.low = (mm == 0) && (ss < LOW) && (m_mode != M_EXP);
    return e;
  endfunction

  task automatic step(input bit rst, input bit ld, input bit rn, input bit bn,
                      input int ox, input int oy, input bit ins);
    @(posedge clk);
    #1;
    resetN = !rst;
    load = ld;
    run = rn;
    addBonus = bn;
    offsetX = 11'(ox);
    offsetY = 11'(oy);
    InsideRectangle = ins;
    if (rst) model_reset();
    sb_q.push_back(model_out(ox, oy, ins));
    if (!rst) model_step(ld, rn, bn);
  endtask

  task automatic rs(input bit rst, input bit ld, input bit rn, input bit bn);
    step(rst, ld, rn, bn, int'($urandom_range(0, 79)), int'($urandom_range(0, 40)),
         ($urandom_range(0, 3) != 0));
  endtask

  task automatic bound_fail(input string name);
    total++;
    bad++;
    $display("FAIL wait_%s: loop bound expired, secs=%0d pre=%0d required target reached", name, m_secs, m_pre);
  endtask

  // Monitor
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = '{digit, digitOffsetX, digitOffsetY, digitInside, timeUp, timeZero, lowTime};
        total++;
        if ({a.dig, a.dox, a.doy, a.din} !== {e.dig, e.dox, e.doy, e.din}) begin
          bad++;
          $display("FAIL display t=%0t got dig=%0d dx=%0d dy=%0d in=%0b want dig=%0d dx=%0d dy=%0d in=%0b (x=%0d y=%0d)",
                   $time, a.dig, a.dox, a.doy, a.din, e.dig, e.dox, e.doy, e.din, offsetX, offsetY);
        end
        total++;
        if ({a.tu, a.tz, a.low} !== {e.tu, e.tz, e.low}) begin
          bad++;
          $display("FAIL status t=%0t got up=%0b zero=%0b low=%0b want up=%0b zero=%0b low=%0b",
                   $time, a.tu, a.tz, a.low, e.tu, e.tz, e.low);
        end
      end
    end
  end

  initial begin
    int n;
    int xs[9];
    model_reset();

    $display("txn reset");
    repeat (3) rs(1, 0, 0, 0);

    $display("txn run from 01:00 to expiry");
    rs(0, 0, 1, 0);
    repeat (60 * CPS + 4) rs(0, 0, 1, 0);
    $display("txn expired: run/bonus ignored");
    repeat (12) rs(0, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    $display("txn load from expired");
    rs(0, 1, 0, 0);
    rs(0, 0, 0, 0);

    $display("txn run to 00:55 then pause with bonus");
    n = 0;
    while (m_secs != 55 && n < 200) begin rs(0, 0, 1, 0); n++; end
    if (n >= 200) bound_fail("55");
    repeat (2) rs(0, 0, 1, 0);
    repeat (10) rs(0, 0, 0, 0);
    rs(0, 0, 0, 1);
    repeat (9) rs(0, 0, 0, 0);
    repeat (12) rs(0, 0, 1, 0);

    $display("txn bonus coincident with tick at 00:01");
    n = 0;
    while (!(m_mode == M_RUN && m_secs == 1 && m_pre == CPS - 1) && n < 400) begin
      rs(0, 0, 1, 0);
      n++;
    end
    if (n >= 400) bound_fail("tick_at_1");
    rs(0, 0, 1, 1);
    repeat (6) rs(0, 0, 1, 0);

    $display("txn bonus saturation at 99:59");
    rs(0, 1, 0, 0);
    repeat (600) rs(0, 0, 0, 1);
    repeat (2 * CPS + 3) rs(0, 0, 1, 1);

    $display("txn load coincident with tick and bonus");
    n = 0;
    while (!(m_mode == M_RUN && m_pre == CPS - 1) && n < 20) begin rs(0, 0, 1, 0); n++; end
    if (n >= 20) bound_fail("tick");
    rs(0, 1, 1, 1);
    repeat (7) rs(0, 0, 1, 0);
    $display("txn async reset mid-run");
    repeat (2) rs(1, 0, 1, 0);
    repeat (3) rs(0, 0, 1, 0);

    $display("txn display slicing at 12:34");
    rs(0, 1, 0, 0);
    repeat (70) rs(0, 0, 0, 1);
    n = 0;
    while (m_secs != 12 * 60 + 34 && n < 100) begin rs(0, 0, 1, 0); n++; end
    if (n >= 100) bound_fail("1234");
    rs(0, 0, 0, 0);
    xs = '{5, 21, 37, 53, 64, 63, 0, 15, 16};
    foreach (xs[i]) step(0, 0, 0, 0, xs[i], 7, 1'b1);
    step(0, 0, 0, 0, 21, 31, 1'b1);
    step(0, 0, 0, 0, 21, 32, 1'b1);
    step(0, 0, 0, 0, 37, 7, 1'b0);

    $display("txn random soak");
    repeat (3000) begin
      rs($urandom_range(0, 499) == 0, $urandom_range(0, 99) == 0,
         $urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0);
    end

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
